// File: rtl/quad_position_counter.sv
// Quadrature encoder front end: synchroniser, glitch filter, Gray-code
// decoder and a loadable up/down position counter with a sticky error flag.
module quad_position_counter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             up_down,
  output logic             err
);

  localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int IW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {INIT, S00, S01, S11, S10} state_t;

  function automatic state_t state_of(input logic [1:0] v);
    case (v)
      2'b01:   return S01;
      2'b11:   return S11;
      2'b10:   return S10;
      default: return S00;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input state_t st);
    case (st)
      S01:     return 2'b01;
      S11:     return 2'b11;
      S10:     return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][RW-1:0]     run_q, run_d;
  state_t                 state_q, state_d;
  logic [IW-1:0]          init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   step_q, step_d;
  logic                   up_down_q, up_down_d;
  logic                   err_q, err_d;

  logic [1:0] s;        // synchronised {a, b}
  logic [1:0] s_next;   // value s takes after this edge
  logic [1:0] cur;      // code of the current decoder state
  logic       illegal;

  assign s      = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign s_next = {sync_a_q[SYNC_STAGES-2], sync_b_q[SYNC_STAGES-2]};
  assign cur    = code_of(state_q);

  // Shift the raw encoder phases through the synchroniser chains.
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
  end

  // Per-bit glitch filter; during INIT f tracks s so the start position is adopted.
  always_comb begin
    filt_d = filt_q;
    run_d  = run_q;
    if (state_q == INIT) begin
      filt_d = s_next;
      run_d  = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] == filt_q[i]) begin
          run_d[i] = '0;
        end else if (run_q[i] == RW'(FILTER_LEN - 1)) begin
          filt_d[i] = s[i];
          run_d[i]  = '0;
        end else begin
          run_d[i] = run_q[i] + RW'(1);
        end
      end
    end
  end

  // Gray-code decoder, counter update, load override and sticky error.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    count_d    = count_q;
    step_d     = 1'b0;
    up_down_d  = up_down_q;
    err_d      = err_q;
    illegal    = 1'b0;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + IW'(1);
      if (init_cnt_q == IW'(SYNC_STAGES - 1)) begin
        state_d    = state_of(s_next);
        init_cnt_d = '0;
      end
    end else if (filt_q != cur) begin
      state_d = state_of(filt_q);
      if (filt_q == {cur[0], ~cur[1]}) begin
        step_d    = 1'b1;
        up_down_d = 1'b1;
        count_d   = count_q + WIDTH'(1);
      end else if (filt_q == {~cur[0], cur[1]}) begin
        step_d    = 1'b1;
        up_down_d = 1'b0;
        count_d   = count_q - WIDTH'(1);
      end else begin
        illegal = 1'b1;
      end
    end
    if (err_clr) err_d = 1'b0;
    if (illegal) err_d = 1'b1;
    if (load)    count_d = data;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      filt_q     <= '0;
      run_q      <= '0;
      state_q    <= INIT;
      init_cnt_q <= '0;
      count_q    <= '0;
      step_q     <= 1'b0;
      up_down_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      filt_q     <= filt_d;
      run_q      <= run_d;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      count_q    <= count_d;
      step_q     <= step_d;
      up_down_q  <= up_down_d;
      err_q      <= err_d;
    end
  end

  assign count   = count_q;
  assign step    = step_q;
  assign up_down = up_down_q;
  assign err     = err_q;

endmodule
